// File: rtl/pattern_det_pkg.sv
// Shared definitions for the multi-channel pattern detector.
//   - mask-source select codes for the per-channel control word
//   - auto-reset mode codes for channel 0
//   - control-word bit positions and a packed view of the control word
package pattern_det_pkg;

  // Mask source select codes (ctrl.sel_mask)
  localparam logic [1:0] SEL_MASK_STATIC = 2'd0;  // table mask
  localparam logic [1:0] SEL_MASK_C      = 2'd1;  // C
  localparam logic [1:0] SEL_MASK_RND1   = 2'd2;  // (~C) << 1
  localparam logic [1:0] SEL_MASK_RND2   = 2'd3;  // (~C) << 2

  // Auto-reset modes for channel 0
  localparam int AR_NONE    = 0;
  localparam int AR_MATCH   = 1;
  localparam int AR_NOMATCH = 2;

  // Control word layout: {en, sel_pattern, sel_mask[1:0]}
  localparam int CTRL_W            = 4;
  localparam int CTRL_EN           = 3;
  localparam int CTRL_SEL_PAT      = 2;
  localparam int CTRL_SEL_MASK_MSB = 1;
  localparam int CTRL_SEL_MASK_LSB = 0;

  // Packed view matching the bit positions above
  typedef struct packed {
    logic       en;
    logic       sel_pattern;
    logic [1:0] sel_mask;
  } ctrl_t;

endpackage

// File: rtl/pattern_det_channel.sv
// One detector channel: pattern/mask selection, match and complement-match
// compare, optional output register, past registers, overflow/underflow
// events, sticky flags and a saturating hit counter.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cep                  clock enable for all state in this channel
//   clr                  clears sticky flags and hit counter (wins over set)
//   p, c                 value under test, dynamic pattern/mask source
//   tbl_pattern/mask     static entry from the config table
//   tbl_ctrl             {en, sel_pattern, sel_mask}
//   pat_det, pat_bdet    detect outputs (registered when PREG=1)
//   overflow, underflow  edge events derived from past registers
//   ovf_sticky, unf_sticky latched events
//   hit_cnt              saturating count of cycles with pat_det=1
//   det_past             previous pat_det, used by the top for auto-reset
module pattern_det_channel
  import pattern_det_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int PREG  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cep,
  input  logic             clr,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] tbl_pattern,
  input  logic [WIDTH-1:0] tbl_mask,
  input  ctrl_t            tbl_ctrl,
  output logic             pat_det,
  output logic             pat_bdet,
  output logic             overflow,
  output logic             underflow,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             det_past
);

  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] mask;
  logic             det;
  logic             bdet;
  logic             bdet_past;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pat  = tbl_pattern;
    mask = tbl_mask;
    if (tbl_ctrl.sel_pattern) pat = c;
    case (tbl_ctrl.sel_mask)
      SEL_MASK_STATIC: mask = tbl_mask;
      SEL_MASK_C:      mask = c;
      SEL_MASK_RND1:   mask = (~c) << 1;
      SEL_MASK_RND2:   mask = (~c) << 2;
      default:         mask = tbl_mask;
    endcase
    // A mask bit of 1 forces that bit position to compare true.
    det  = tbl_ctrl.en & (&(~(p ^ pat) | mask));
    bdet = tbl_ctrl.en & (&((p ^ pat) | mask));
  end

  generate
    if (PREG == 1) begin : g_preg
      logic det_q;
      logic bdet_q;
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          det_q  <= 1'b0;
          bdet_q <= 1'b0;
        end else if (cep) begin
          det_q  <= det;
          bdet_q <= bdet;
        end
      end
      assign pat_det  = det_q;
      assign pat_bdet = bdet_q;
    end else begin : g_comb
      assign pat_det  = det;
      assign pat_bdet = bdet;
    end
  endgenerate

  // Past registers follow the post-PREG outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_past  <= 1'b0;
      bdet_past <= 1'b0;
    end else if (cep) begin
      det_past  <= pat_det;
      bdet_past <= pat_bdet;
    end
  end

  // A match (or complement match) that has just been lost without the other
  // appearing in its place.
  assign overflow  = det_past  & ~pat_det & ~pat_bdet;
  assign underflow = bdet_past & ~pat_det & ~pat_bdet;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      hit_cnt    <= '0;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      hit_cnt    <= '0;
    end else if (cep) begin
      if (overflow)  ovf_sticky <= 1'b1;
      if (underflow) unf_sticky <= 1'b1;
      if (pat_det && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_detector_mc.sv
// Multi-channel pattern detector for the DSP slice output stage.
// Holds the runtime-writable pattern/mask/ctrl table, decodes table writes,
// instantiates one detector channel per entry and drives the channel-0
// auto-reset request for the P register.
// Ports:
//   clk, RSTn            clock, asynchronous active-low reset
//   CEP                  clock enable for detect/past/counter state
//   P, C                 value under test, dynamic pattern/mask source
//   cfg_we, cfg_addr     table write strobe and channel (out of range ignored)
//   cfg_pattern/mask     static pattern and mask (mask 1 = ignore bit)
//   cfg_ctrl             {en, sel_pattern, sel_mask[1:0]}
//   clr                  clears sticky flags and hit counters
//   PATTERNDETECT/PATTERNBDETECT, OVERFLOW/UNDERFLOW, OVF/UNF_STICKY  per channel
//   HIT_CNT              channel k at [k*CNT_W +: CNT_W]
//   AUTORESET_P          P-register reset request from channel 0
module pattern_detector_mc
  import pattern_det_pkg::*;
#(
  parameter int WIDTH            = 48,
  parameter int NCH              = 4,
  parameter int PREG             = 1,
  parameter int AUTORESET_PATDET = 0,
  parameter int CNT_W            = 8
) (
  input  logic                                 clk,
  input  logic                                 RSTn,
  input  logic                                 CEP,
  input  logic [WIDTH-1:0]                     P,
  input  logic [WIDTH-1:0]                     C,
  input  logic                                 cfg_we,
  input  logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]                     cfg_pattern,
  input  logic [WIDTH-1:0]                     cfg_mask,
  input  logic [CTRL_W-1:0]                    cfg_ctrl,
  input  logic                                 clr,
  output logic [NCH-1:0]                       PATTERNDETECT,
  output logic [NCH-1:0]                       PATTERNBDETECT,
  output logic [NCH-1:0]                       OVERFLOW,
  output logic [NCH-1:0]                       UNDERFLOW,
  output logic [NCH-1:0]                       OVF_STICKY,
  output logic [NCH-1:0]                       UNF_STICKY,
  output logic [NCH*CNT_W-1:0]                 HIT_CNT,
  output logic                                 AUTORESET_P
);

  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [WIDTH-1:0] tbl_pattern [NCH];
  logic [WIDTH-1:0] tbl_mask    [NCH];
  ctrl_t            tbl_ctrl    [NCH];
  logic [NCH-1:0]   det_past;

  // NOTE: the table is a handful of flops, not a RAM, and it has defined
  // reset contents (all channels disabled), so it is reset like any register.
  // Writes ignore CEP; a write lands at the edge, so the channel compares
  // against the old entry in the write cycle and the new one afterwards.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < NCH; k++) begin
        tbl_pattern[k] <= '0;
        tbl_mask[k]    <= '1;
        tbl_ctrl[k]    <= '0;
      end
    end else if (cfg_we) begin
      // Only addresses that match a channel index write; the rest fall through.
      for (int k = 0; k < NCH; k++) begin
        if (cfg_addr == AW'(k)) begin
          tbl_pattern[k] <= cfg_pattern;
          tbl_mask[k]    <= cfg_mask;
          tbl_ctrl[k]    <= ctrl_t'(cfg_ctrl);
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      pattern_det_channel #(
        .WIDTH (WIDTH),
        .PREG  (PREG),
        .CNT_W (CNT_W)
      ) u_ch (
        .clk         (clk),
        .rst_n       (RSTn),
        .cep         (CEP),
        .clr         (clr),
        .p           (P),
        .c           (C),
        .tbl_pattern (tbl_pattern[k]),
        .tbl_mask    (tbl_mask[k]),
        .tbl_ctrl    (tbl_ctrl[k]),
        .pat_det     (PATTERNDETECT[k]),
        .pat_bdet    (PATTERNBDETECT[k]),
        .overflow    (OVERFLOW[k]),
        .underflow   (UNDERFLOW[k]),
        .ovf_sticky  (OVF_STICKY[k]),
        .unf_sticky  (UNF_STICKY[k]),
        .hit_cnt     (HIT_CNT[k*CNT_W +: CNT_W]),
        .det_past    (det_past[k])
      );
    end
  endgenerate

  // Only channel 0's past value drives auto-reset; the others are spare.
  logic unused_det_past;
  assign unused_det_past = ^det_past;

  always_comb begin
    AUTORESET_P = 1'b0;
    case (AUTORESET_PATDET)
      AR_MATCH:   AUTORESET_P = CEP & PATTERNDETECT[0];
      AR_NOMATCH: AUTORESET_P = CEP & ~PATTERNDETECT[0] & det_past[0];
      default:    AUTORESET_P = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pattern_detector_mc.sv
// Directed bench: dut_a (NCH=3, PREG=1, auto-reset on match, CNT_W=4) and
// dut_b (NCH=1, PREG=0, auto-reset on lost match) share stimulus.
module tb_pattern_detector_mc;

  localparam int W     = 48;
  localparam int NCH   = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cep, clr, cfg_we, cfg_we_b, cfg_addr_b;
  logic [W-1:0]  p, c, cfg_pattern, cfg_mask;
  logic [1:0]    cfg_addr;
  logic [3:0]    cfg_ctrl;

  logic [NCH-1:0]       pd, pbd, ovf, unf, ovf_st, unf_st;
  logic [NCH*CNT_W-1:0] hit;
  logic                 ar;
  logic                 pd_b, pbd_b, ovf_b, unf_b, ovf_st_b, unf_st_b, ar_b;
  logic [CNT_W-1:0]     hit_b;

  pattern_detector_mc #(
    .WIDTH(W), .NCH(NCH), .PREG(1), .AUTORESET_PATDET(1), .CNT_W(CNT_W)
  ) dut_a (
    .clk(clk), .RSTn(rst_n), .CEP(cep), .P(p), .C(c),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_ctrl(cfg_ctrl), .clr(clr),
    .PATTERNDETECT(pd), .PATTERNBDETECT(pbd), .OVERFLOW(ovf), .UNDERFLOW(unf),
    .OVF_STICKY(ovf_st), .UNF_STICKY(unf_st), .HIT_CNT(hit), .AUTORESET_P(ar)
  );

  pattern_detector_mc #(
    .WIDTH(W), .NCH(1), .PREG(0), .AUTORESET_PATDET(2), .CNT_W(CNT_W)
  ) dut_b (
    .clk(clk), .RSTn(rst_n), .CEP(cep), .P(p), .C(c),
    .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_ctrl(cfg_ctrl), .clr(clr),
    .PATTERNDETECT(pd_b), .PATTERNBDETECT(pbd_b), .OVERFLOW(ovf_b),
    .UNDERFLOW(unf_b), .OVF_STICKY(ovf_st_b), .UNF_STICKY(unf_st_b),
    .HIT_CNT(hit_b), .AUTORESET_P(ar_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [1:0] addr, input logic [W-1:0] pat,
                           input logic [W-1:0] msk, input logic [3:0] ctrl,
                           input logic also_b);
    cfg_addr    = addr;
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_ctrl    = ctrl;
    cfg_we      = 1'b1;
    cfg_we_b    = also_b;
    tick();
    cfg_we      = 1'b0;
    cfg_we_b    = 1'b0;
  endtask

  // Channel-0 vectors: inputs applied, one edge, then expected
  // {PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW, OVF_STICKY, UNF_STICKY}.
  typedef struct {
    logic [W-1:0] p;
    logic         cep;
    logic         clr;
    logic [5:0]   exp;
  } vec_t;

  vec_t vecs [13];

  localparam logic [W-1:0] P_4 = 48'h4000_0000_0000;
  localparam logic [W-1:0] P_8 = 48'h8000_0000_0000;
  localparam logic [W-1:0] P_C = 48'hC000_0000_0000;

  initial begin
    vecs[0]  = '{p: 48'h1, cep: 1'b1, clr: 1'b0, exp: 6'b100000};
    vecs[1]  = '{p: P_4,   cep: 1'b1, clr: 1'b0, exp: 6'b001000};
    vecs[2]  = '{p: P_4,   cep: 1'b1, clr: 1'b0, exp: 6'b000010};
    vecs[3]  = '{p: P_C,   cep: 1'b1, clr: 1'b0, exp: 6'b010010};
    vecs[4]  = '{p: P_8,   cep: 1'b1, clr: 1'b0, exp: 6'b000110};
    vecs[5]  = '{p: P_8,   cep: 1'b1, clr: 1'b0, exp: 6'b000011};
    vecs[6]  = '{p: P_8,   cep: 1'b1, clr: 1'b1, exp: 6'b000000};
    vecs[7]  = '{p: P_C,   cep: 1'b0, clr: 1'b0, exp: 6'b000000};
    vecs[8]  = '{p: P_C,   cep: 1'b1, clr: 1'b0, exp: 6'b010000};
    vecs[9]  = '{p: 48'h0, cep: 1'b0, clr: 1'b0, exp: 6'b010000};
    vecs[10] = '{p: P_4,   cep: 1'b1, clr: 1'b0, exp: 6'b000100};
    vecs[11] = '{p: 48'h0, cep: 1'b0, clr: 1'b0, exp: 6'b000100};
    vecs[12] = '{p: 48'h0, cep: 1'b1, clr: 1'b0, exp: 6'b100001};

    rst_n = 1'b0; cep = 1'b1; clr = 1'b0; p = '0; c = '0;
    cfg_we = 1'b0; cfg_we_b = 1'b0; cfg_addr = '0; cfg_addr_b = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_ctrl = '0;

    // Reset state
    #12;
    check("reset_a", {pd, pbd, ovf, unf, ovf_st, unf_st, hit, ar}, '0);
    check("reset_b", {pd_b, pbd_b, ovf_b, unf_b, ovf_st_b, unf_st_b, hit_b, ar_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table resets to disabled: nothing matches
    p = 48'h1;
    tick();
    check("disabled_pd", pd, 3'b000);

    // Channel 0 (both DUTs): pattern 0, only bits 47:46 compared, enabled
    p = '0;
    write_cfg(2'd0, '0, 48'h3FFF_FFFF_FFFF, 4'b1000, 1'b1);

    for (int i = 0; i < 13; i++) begin
      p   = vecs[i].p;
      cep = vecs[i].cep;
      clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i), {pd[0], pbd[0], ovf[0], unf[0], ovf_st[0], unf_st[0]},
            vecs[i].exp);
    end
    cep = 1'b1;
    clr = 1'b0;

    // Dynamic pattern = C, masks derived from C (channel 1)
    c = 48'hF0;
    write_cfg(2'd1, '0, '0, 4'b1110, 1'b0);   // mask = (~C)<<1 = ..FE1E
    p = 48'hF0; tick(); check("rnd1_eq",    pd[1], 1'b1);
    p = 48'hE0; tick(); check("rnd1_bit4",  pd[1], 1'b1);  // bit 4 masked
    p = 48'hD0; tick(); check("rnd1_bit5",  pd[1], 1'b0);
    p = 48'hF1; tick(); check("rnd1_bit0",  pd[1], 1'b0);  // bit 0 never masked
    write_cfg(2'd1, '0, '0, 4'b1111, 1'b0);   // mask = (~C)<<2 = ..FC3C
    p = 48'hD0; tick(); check("rnd2_bit5",  pd[1], 1'b1);
    p = 48'hB0; tick(); check("rnd2_bit6",  pd[1], 1'b0);
    write_cfg(2'd1, '0, '0, 4'b1101, 1'b0);   // mask = C
    p = 48'hA0; tick(); check("maskc_eq",   pd[1], 1'b1);

    // Saturating counter on channel 2
    write_cfg(2'd2, 48'h5, '0, 4'b1000, 1'b0);
    p = 48'h5; clr = 1'b1; tick(); clr = 1'b0;
    repeat (5) tick();
    check("cnt_5", hit[8 +: 4], 4'd5);
    repeat (17) tick();
    check("cnt_sat", hit[8 +: 4], 4'd15);
    clr = 1'b1; tick(); clr = 1'b0;
    check("cnt_clr_wins", hit[8 +: 4], 4'd0);
    cep = 1'b0; repeat (3) tick();
    check("cnt_cep_hold", hit[8 +: 4], 4'd0);
    cep = 1'b1;

    // Write concurrent with evaluation on channel 1
    write_cfg(2'd1, 48'hAA, '0, 4'b1000, 1'b0);
    p = 48'hAA;
    write_cfg(2'd1, 48'h55, '0, 4'b1000, 1'b0);
    check("wr_old_entry", pd[1], 1'b1);
    tick();
    check("wr_new_entry", pd[1], 1'b0);
    p = 48'h55; tick();
    check("wr_new_match", pd[1], 1'b1);
    write_cfg(2'd3, '0, '1, 4'b1000, 1'b0);   // out of range
    tick();
    check("wr_oob_ignored", pd, 3'b011);

    // Auto-reset on match (dut_a)
    check("ar_match", ar, 1'b1);
    cep = 1'b0; #1;
    check("ar_cep0", ar, 1'b0);
    cep = 1'b1; p = P_4; tick();
    check("ar_nomatch", ar, 1'b0);

    // Combinational path and auto-reset on lost match (dut_b)
    p = 48'h1; #1;
    check("b_comb_pd", pd_b, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("b_st_clr", ovf_st_b, 1'b0);
    p = P_4; #1;
    check("b_ovf_ar", {ovf_b, ar_b}, 2'b11);
    cep = 1'b0; #1;
    check("b_ar_cep0", ar_b, 1'b0);
    cep = 1'b1; tick();
    check("b_after", {ovf_st_b, ovf_b, ar_b}, 3'b100);

    // Asynchronous reset mid-count
    p = 48'h5; repeat (3) tick();
    check("pre_rst_cnt", hit[8 +: 4], 4'd2);
    #2 rst_n = 1'b0; #1;
    check("async_rst_a", {pd, pbd, ovf, unf, ovf_st, unf_st, hit, ar}, '0);
    check("async_rst_b", {pd_b, pbd_b, ovf_b, unf_b, ovf_st_b, unf_st_b, hit_b, ar_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_tbl", {pd, pd_b}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
